// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage mult/div issue gate for MultDivUnit, with a predicted-busy
// countdown, D-stage stall generation and a sticky MDU busy mismatch flag.
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [2:0] e_md_op,
  input  logic       e_flush,
  input  logic       d_md_use,
  input  logic       mdu_busy,
  output logic       mdu_start,
  output logic [2:0] mdu_op,
  output logic       stall_d,
  output logic [3:0] remain,
  output logic       mdu_err
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_remain, w_remain_nxt;
  logic       r_err;
  logic       w_live, w_is_md, w_pb, w_bypass;
  assign w_live   = e_valid & ~e_flush & reset;
  assign w_is_md  = w_live & ~e_md_op[2];
  assign w_pb     = r_state != IDLE;
  // an md-class op reaching E while busy means the D stall was bypassed
  assign w_bypass = w_live & w_pb & (e_md_op <= 3'b101);
  assign mdu_start = w_is_md & ~w_pb;
  assign mdu_op    = (w_live & ~w_pb) ? e_md_op : 3'b110;
  assign stall_d   = reset & d_md_use & (mdu_start | w_pb);
  assign remain    = r_remain;
  assign mdu_err   = r_err;
  always_comb begin
    w_next       = r_state;
    w_remain_nxt = r_remain;
    if (mdu_start) begin
      w_next       = e_md_op[1] ? DIV : MUL;
      w_remain_nxt = e_md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (w_pb) begin
      w_next       = (r_remain == 4'd1) ? IDLE : r_state;
      w_remain_nxt = r_remain - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_remain <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_remain <= w_remain_nxt;
      r_err    <= r_err | (w_pb != mdu_busy) | w_bypass;
    end
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: per-cycle vector table for md_issue_ctrl plus a hand-run
// mult sequence with a bench-side MDU busy model.
module tb_md_issue_ctrl;
  logic       clk = 0;
  logic       reset, e_valid, e_flush, d_md_use, mdu_busy;
  logic [2:0] e_md_op;
  logic       mdu_start, stall_d, mdu_err;
  logic [2:0] mdu_op;
  logic [3:0] remain;

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
    .e_flush(e_flush), .d_md_use(d_md_use), .mdu_busy(mdu_busy),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .stall_d(stall_d),
    .remain(remain), .mdu_err(mdu_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, val;
    logic [2:0] op;
    logic       fl, du, busy;
    logic       st;
    logic [2:0] mop;
    logic       stl;
    logic [3:0] rem;
    logic       err;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst, val, input logic [2:0] op,
                              input logic fl, du, busy, st, input logic [2:0] mop,
                              input logic stl, input logic [3:0] rem, input logic err);
    vec_t v;
    v.rst = rst; v.val = val; v.op = op; v.fl = fl; v.du = du; v.busy = busy;
    v.st = st; v.mop = mop; v.stl = stl; v.rem = rem; v.err = err;
    vq.push_back(v);
  endfunction

  task automatic chk(input int idx, input vec_t v);
    n_vec++;
    if (mdu_start !== v.st || mdu_op !== v.mop || stall_d !== v.stl ||
        remain !== v.rem || mdu_err !== v.err) begin
      n_bad++;
      $display("FAIL vec%0d: got start=%b op=%b stall=%b remain=%0d err=%b, want start=%b op=%b stall=%b remain=%0d err=%b",
               idx, mdu_start, mdu_op, stall_d, remain, mdu_err,
               v.st, v.mop, v.stl, v.rem, v.err);
    end
  endtask

  initial begin
    int cnt;
    // T1 reset, then mult: start 1 cycle, remain 5..1, stall 6 cycles
    add(0,1,3'b000,0,1,0, 0,3'b110,0,4'd0,0);
    add(1,0,3'b110,0,1,0, 0,3'b110,0,4'd0,0);
    add(1,1,3'b000,0,1,0, 1,3'b000,1,4'd0,0);
    for (int i = 5; i >= 1; i--) add(1,0,3'b110,0,1,1, 0,3'b110,1,4'(i),0);
    add(1,0,3'b110,0,1,0, 0,3'b110,0,4'd0,0);
    // T2 divu: remain 10..1, stall 11 cycles
    add(1,1,3'b011,0,1,0, 1,3'b011,1,4'd0,0);
    for (int i = 10; i >= 1; i--) add(1,0,3'b110,0,1,1, 0,3'b110,1,4'(i),0);
    add(1,0,3'b110,0,1,0, 0,3'b110,0,4'd0,0);
    // T3 flushed mult never issues
    add(1,1,3'b000,1,1,0, 0,3'b110,0,4'd0,0);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd0,0);
    // T4 mthi/mtlo pass through without start; flushed mthi suppressed
    add(1,1,3'b100,0,1,0, 0,3'b100,0,4'd0,0);
    add(1,1,3'b101,0,1,0, 0,3'b101,0,4'd0,0);
    add(1,1,3'b100,1,1,0, 0,3'b110,0,4'd0,0);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd0,0);
    // T5 div, reset at remain 6, then multu counts from 5
    add(1,1,3'b010,0,0,0, 1,3'b010,0,4'd0,0);
    for (int i = 10; i >= 7; i--) add(1,0,3'b110,0,0,1, 0,3'b110,0,4'(i),0);
    add(0,0,3'b110,0,1,1, 0,3'b110,0,4'd6,0);
    add(1,0,3'b110,0,1,0, 0,3'b110,0,4'd0,0);
    add(1,1,3'b001,0,0,0, 1,3'b001,0,4'd0,0);
    for (int i = 5; i >= 1; i--) add(1,0,3'b110,0,0,1, 0,3'b110,0,4'(i),0);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd0,0);
    // T6 busy dropped at remain 3: sticky error until reset
    add(1,1,3'b000,0,0,0, 1,3'b000,0,4'd0,0);
    add(1,0,3'b110,0,0,1, 0,3'b110,0,4'd5,0);
    add(1,0,3'b110,0,0,1, 0,3'b110,0,4'd4,0);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd3,0);
    add(1,0,3'b110,0,0,1, 0,3'b110,0,4'd2,1);
    add(1,0,3'b110,0,0,1, 0,3'b110,0,4'd1,1);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd0,1);
    add(1,1,3'b000,0,0,0, 1,3'b000,0,4'd0,1);
    add(0,0,3'b110,0,0,1, 0,3'b110,0,4'd5,1);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd0,0);
    // T7 md op bypassing the stall while busy; flush does not cancel
    add(1,1,3'b001,0,1,0, 1,3'b001,1,4'd0,0);
    add(1,1,3'b010,0,1,1, 0,3'b110,1,4'd5,0);
    add(1,0,3'b110,0,1,1, 0,3'b110,1,4'd4,1);
    add(1,1,3'b100,0,1,1, 0,3'b110,1,4'd3,1);
    add(1,1,3'b000,1,1,1, 0,3'b110,1,4'd2,1);
    add(1,0,3'b110,0,1,1, 0,3'b110,1,4'd1,1);
    add(1,0,3'b110,0,0,0, 0,3'b110,0,4'd0,1);

    reset = 0; e_valid = 0; e_md_op = 3'b110; e_flush = 0; d_md_use = 0; mdu_busy = 0;
    @(posedge clk);
    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; e_valid = vq[i].val; e_md_op = vq[i].op;
      e_flush = vq[i].fl; d_md_use = vq[i].du; mdu_busy = vq[i].busy;
      #1 chk(i, vq[i]);
    end

    // hand-run mult after reset with modelled busy: stall 6 cycles, no error
    @(negedge clk);
    reset = 0; e_valid = 0; e_md_op = 3'b110; d_md_use = 0; mdu_busy = 0;
    @(negedge clk);
    reset = 1; e_valid = 1; e_md_op = 3'b000; d_md_use = 1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall_d) break;
      cnt++;
      @(negedge clk);
      e_valid = 0; e_md_op = 3'b110; mdu_busy = (c < 5);
    end
    n_vec++;
    if (cnt != 6) begin
      n_bad++;
      $display("FAIL seq_stall_len: got %0d cycles, want 6", cnt);
    end
    n_vec++;
    if (mdu_err !== 1'b0 || remain !== 4'd0) begin
      n_bad++;
      $display("FAIL seq_end_state: got err=%b remain=%0d, want err=0 remain=0", mdu_err, remain);
    end
    d_md_use = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
